// File: rtl/reg_bank_avalon_interface_if.sv
// Avalon-MM slave bus bundle for the register bank: request side in, read return out.
interface reg_bank_avalon_interface_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 3
) ();
   logic                      chipselect;
   logic [ADDR_WIDTH-1:0]     address;
   logic                      read;
   logic                      write;
   logic [DATA_WIDTH-1:0]     writedata;
   logic [DATA_WIDTH/8-1:0]   byteenable;
   logic [DATA_WIDTH-1:0]     readdata;
   logic                      readdatavalid;

   modport master (
      output chipselect, address, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

   modport slave (
      input  chipselect, address, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/reg_bank_avalon_interface.sv
// Avalon-MM register bank: NUM_REGS-2 general registers, a sticky W1C STATUS
// register fed by hw_set, a MASK register, registered irq, 1-cycle read latency.
module reg_bank_avalon_interface #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                            clock,
   input  logic                            resetn,
   reg_bank_avalon_interface_if.slave      bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0]  Q,
   output logic [NUM_REGS-1:0]             wr_strobe,
   input  logic [DATA_WIDTH-1:0]           hw_set,
   output logic                            irq
);
   localparam int unsigned NUM_LANES  = DATA_WIDTH / 8;
   localparam int unsigned STATUS_IDX = NUM_REGS - 2;
   localparam int unsigned MASK_IDX   = NUM_REGS - 1;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [DATA_WIDTH-1:0] lane_mask;
   logic [DATA_WIDTH-1:0] status_clr;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic [NUM_REGS-1:0]   wr_sel;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accepted transactions are qualified by chipselect.
   assign wr_acc = bus.chipselect & bus.write;
   assign rd_acc = bus.chipselect & bus.read;

   // Expand byte enables to a bit mask over the data word.
   always_comb begin
      lane_mask = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         lane_mask[8*i +: 8] = {8{bus.byteenable[i]}};
      end
   end

   // One-hot register select for an accepted write with any lane enabled;
   // out-of-range addresses match no register and are dropped.
   always_comb begin
      wr_sel = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (wr_acc && (bus.address == ADDR_WIDTH'(k)) && (|bus.byteenable)) begin
            wr_sel[k] = 1'b1;
         end
      end
   end

   // Next register values: byte merge for plain registers, sticky set/clear for STATUS.
   always_comb begin
      status_clr = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         if (wr_sel[k] && (k != STATUS_IDX)) begin
            regs_d[k] = (regs_q[k] & ~lane_mask) | (bus.writedata & lane_mask);
         end
      end
      if (wr_sel[STATUS_IDX]) begin
         status_clr = bus.writedata & lane_mask;
      end
      // hw_set is applied after the clear so a simultaneous set wins.
      regs_d[STATUS_IDX] = (regs_q[STATUS_IDX] & ~status_clr) | hw_set;
   end

   // Read mux on pre-update values; unmapped addresses read as zero.
   always_comb begin
      rd_mux = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (bus.address == ADDR_WIDTH'(k)) begin
            rd_mux = regs_q[k];
         end
      end
   end

   // Register bank and per-register write strobes.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
         wr_strobe <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
         wr_strobe <= wr_sel;
      end
   end

   // Read return path: one-cycle latency, data held between reads.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bus.readdata      <= '0;
         bus.readdatavalid <= 1'b0;
      end else begin
         bus.readdatavalid <= rd_acc;
         if (rd_acc) begin
            bus.readdata <= rd_mux;
         end
      end
   end

   // Interrupt follows the current STATUS and MASK contents with one cycle of lag.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         irq <= 1'b0;
      end else begin
         irq <= |(regs_q[STATUS_IDX] & regs_q[MASK_IDX]);
      end
   end

   // Flattened view of all registers for the datapath.
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
      assign Q[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
   end

endmodule

// File: tb/tb_reg_bank_avalon_interface.sv
// Bench for reg_bank_avalon_interface: directed stimulus, reference model of the
// register map checked every cycle, plus literal expectations from worked examples.
module tb_reg_bank_avalon_interface;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 3;
   localparam int unsigned NR  = 8;
   localparam int unsigned NR6 = 6;

   logic clock  = 1'b0;
   logic resetn = 1'b1;
   always #5 clock = ~clock;

   reg_bank_avalon_interface_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus8 ();
   reg_bank_avalon_interface_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus6 ();

   logic [NR*DW-1:0]  q8;
   logic [NR-1:0]     strb8;
   logic [DW-1:0]     hw8;
   logic              irq8;
   logic [NR6*DW-1:0] q6;
   logic [NR6-1:0]    strb6;
   logic [DW-1:0]     hw6;
   logic              irq6;

   reg_bank_avalon_interface #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut8 (
      .clock(clock), .resetn(resetn), .bus(bus8),
      .Q(q8), .wr_strobe(strb8), .hw_set(hw8), .irq(irq8)
   );

   reg_bank_avalon_interface #(.DATA_WIDTH(DW), .NUM_REGS(NR6), .ADDR_WIDTH(AW)) dut6 (
      .clock(clock), .resetn(resetn), .bus(bus6),
      .Q(q6), .wr_strobe(strb6), .hw_set(hw6), .irq(irq6)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv8(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be);
      bus8.chipselect = cs;
      bus8.read       = rd;
      bus8.write      = wr;
      bus8.address    = a;
      bus8.writedata  = d;
      bus8.byteenable = be;
   endtask

   task automatic drv6(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be);
      bus6.chipselect = cs;
      bus6.read       = rd;
      bus6.write      = wr;
      bus6.address    = a;
      bus6.writedata  = d;
      bus6.byteenable = be;
   endtask

   // Reference model of the 8-register bank, updated from the sampled bus.
   logic [DW-1:0] m_reg [NR];
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic          m_irq;
   logic [NR-1:0] m_strb;

   always @(posedge clock or negedge resetn) begin : model
      logic [DW-1:0] nr [NR];
      logic [DW-1:0] clr;
      logic [NR-1:0] st;
      int unsigned   a;
      if (!resetn) begin
         for (int k = 0; k < NR; k++) m_reg[k] <= '0;
         m_rdata  <= '0;
         m_rvalid <= 1'b0;
         m_irq    <= 1'b0;
         m_strb   <= '0;
      end else begin
         nr  = m_reg;
         clr = '0;
         st  = '0;
         a   = 32'(bus8.address);
         m_irq <= (m_reg[NR-2] & m_reg[NR-1]) != '0;
         if (bus8.chipselect && bus8.read) begin
            m_rvalid <= 1'b1;
            m_rdata  <= (a < NR) ? m_reg[a] : '0;
         end else begin
            m_rvalid <= 1'b0;
         end
         if (bus8.chipselect && bus8.write && (a < NR) && (bus8.byteenable != '0)) begin
            st[a] = 1'b1;
            for (int b = 0; b < DW/8; b++) begin
               if (bus8.byteenable[b]) begin
                  if (a == NR-2) clr[8*b +: 8] = bus8.writedata[8*b +: 8];
                  else           nr[a][8*b +: 8] = bus8.writedata[8*b +: 8];
               end
            end
         end
         nr[NR-2] = (m_reg[NR-2] & ~clr) | hw8;
         m_strb <= st;
         m_reg  <= nr;
      end
   end

   // Every-cycle comparison of the 8-register DUT against the model.
   always @(negedge clock) begin : compare
      logic [NR*DW-1:0] mq;
      for (int k = 0; k < NR; k++) mq[k*DW +: DW] = m_reg[k];
      chk("model_q",      256'(q8),                  256'(mq));
      chk("model_strobe", 256'(strb8),               256'(m_strb));
      chk("model_rvalid", 256'(bus8.readdatavalid),  256'(m_rvalid));
      chk("model_rdata",  256'(bus8.readdata),       256'(m_rdata));
      chk("model_irq",    256'(irq8),                256'(m_irq));
   end

   initial begin
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drv6(1'b0, 1'b0, 1'b0, '0, '0, '0);
      hw8 = '0;
      hw6 = '0;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_q",      256'(q8),                 256'(0));
      chk("rst_strobe", 256'(strb8),              256'(0));
      chk("rst_irq",    256'(irq8),               256'(0));
      chk("rst_rvalid", 256'(bus8.readdatavalid), 256'(0));
      chk("rst_rdata",  256'(bus8.readdata),      256'(0));
      resetn = 1'b1;

      // Read every address back to back after reset.
      for (int a = 0; a < 8; a++) begin
         drv8(1'b1, 1'b1, 1'b0, AW'(a), '0, '0);
         @(negedge clock);
         chk("rd_all_valid", 256'(bus8.readdatavalid), 256'(1'b1));
         chk("rd_all_zero",  256'(bus8.readdata),      256'(0));
      end
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clock);
      chk("rd_all_done", 256'(bus8.readdatavalid), 256'(1'b0));

      // Byte-enabled partial write over a preloaded value.
      drv8(1'b1, 1'b0, 1'b1, 3'd1, 32'h11223344, 4'hF);
      @(negedge clock);
      chk("preload_strobe", 256'(strb8), 256'(8'h02));
      drv8(1'b1, 1'b0, 1'b1, 3'd1, 32'hDEADBEEF, 4'b0101);
      @(negedge clock);
      chk("be_merge",  256'(q8[1*DW +: DW]), 256'(32'h11AD33EF));
      chk("be_strobe", 256'(strb8),          256'(8'h02));
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clock);
      chk("strobe_one_cycle", 256'(strb8), 256'(0));
      drv8(1'b1, 1'b1, 1'b0, 3'd1, '0, '0);
      @(negedge clock);
      chk("be_readback", 256'(bus8.readdata),      256'(32'h11AD33EF));
      chk("be_rvalid",   256'(bus8.readdatavalid), 256'(1'b1));

      // hw_set pulse with MASK=0x4 raises irq one cycle after STATUS.
      drv8(1'b1, 1'b0, 1'b1, 3'd7, 32'h4, 4'hF);
      @(negedge clock);
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      hw8 = 32'h5;
      @(negedge clock);
      hw8 = '0;
      chk("status_set",    256'(q8[6*DW +: DW]), 256'(32'h5));
      chk("irq_lag",       256'(irq8),           256'(1'b0));
      @(negedge clock);
      chk("irq_high",      256'(irq8),           256'(1'b1));

      // W1C of the masked bit drops irq one cycle later.
      drv8(1'b1, 1'b0, 1'b1, 3'd6, 32'h4, 4'hF);
      @(negedge clock);
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk("status_w1c",    256'(q8[6*DW +: DW]), 256'(32'h1));
      chk("irq_clr_lag",   256'(irq8),           256'(1'b1));
      @(negedge clock);
      chk("irq_low",       256'(irq8),           256'(1'b0));

      // Set wins over clear on the same bit.
      hw8 = 32'h1;
      drv8(1'b1, 1'b0, 1'b1, 3'd6, 32'h1, 4'hF);
      @(negedge clock);
      hw8 = '0;
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk("set_wins", 256'(q8[6*DW +: DW]), 256'(32'h1));

      // Same-cycle read and write of reg 0 returns the old value.
      drv8(1'b1, 1'b1, 1'b1, 3'd0, 32'hA5A5A5A5, 4'hF);
      @(negedge clock);
      chk("rw_old_data", 256'(bus8.readdata),  256'(0));
      chk("rw_written",  256'(q8[0 +: DW]),    256'(32'hA5A5A5A5));
      drv8(1'b1, 1'b1, 1'b0, 3'd0, '0, '0);
      @(negedge clock);
      chk("rw_new_data", 256'(bus8.readdata),  256'(32'hA5A5A5A5));

      // Write without chipselect is ignored.
      drv8(1'b0, 1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
      @(negedge clock);
      chk("nocs_q",      256'(q8[2*DW +: DW]), 256'(0));
      chk("nocs_strobe", 256'(strb8),          256'(0));

      // Mixed lane writes, MASK=0x1, then a burst of reads.
      drv8(1'b1, 1'b0, 1'b1, 3'd3, 32'hAB000000, 4'b1000);
      @(negedge clock);
      drv8(1'b1, 1'b0, 1'b1, 3'd4, 32'h1234BEEF, 4'b0011);
      @(negedge clock);
      drv8(1'b1, 1'b0, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF);
      @(negedge clock);
      drv8(1'b1, 1'b0, 1'b1, 3'd7, 32'h1, 4'hF);
      @(negedge clock);
      chk("lane_hi", 256'(q8[3*DW +: DW]), 256'(32'hAB000000));
      chk("lane_lo", 256'(q8[4*DW +: DW]), 256'(32'h0000BEEF));
      for (int a = 0; a < 8; a++) begin
         drv8(1'b1, 1'b1, 1'b0, AW'(a), '0, '0);
         @(negedge clock);
      end
      chk("burst_last", 256'(bus8.readdata), 256'(32'h1));
      chk("irq_mask1",  256'(irq8),          256'(1'b1));
      drv8(1'b1, 1'b1, 1'b0, 3'd2, '0, '0);
      @(negedge clock);
      chk("rd_reg2", 256'(bus8.readdata), 256'(32'hCAFEF00D));
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);

      // Six-register instance: address 7 is unmapped.
      drv6(1'b1, 1'b0, 1'b1, 3'd0, 32'h12345678, 4'hF);
      @(negedge clock);
      chk("n6_strobe", 256'(strb6), 256'(6'h01));
      drv6(1'b1, 1'b0, 1'b1, 3'd7, 32'hFFFFFFFF, 4'hF);
      @(negedge clock);
      chk("n6_oor_q",      256'(q6),    256'(32'h12345678));
      chk("n6_oor_strobe", 256'(strb6), 256'(0));
      drv6(1'b1, 1'b1, 1'b0, 3'd0, '0, '0);
      @(negedge clock);
      chk("n6_rd0", 256'(bus6.readdata), 256'(32'h12345678));
      drv6(1'b1, 1'b1, 1'b0, 3'd7, '0, '0);
      @(negedge clock);
      chk("n6_oor_rdata",  256'(bus6.readdata),      256'(0));
      chk("n6_oor_rvalid", 256'(bus6.readdatavalid), 256'(1'b1));
      drv6(1'b0, 1'b0, 1'b0, '0, '0, '0);

      // Asynchronous reset between edges while a read is returning.
      drv8(1'b1, 1'b1, 1'b0, 3'd2, '0, '0);
      @(posedge clock);
      #2;
      chk("pre_rst_rvalid", 256'(bus8.readdatavalid), 256'(1'b1));
      #1 resetn = 1'b0;
      #1;
      chk("arst_q",      256'(q8),                 256'(0));
      chk("arst_rvalid", 256'(bus8.readdatavalid), 256'(0));
      chk("arst_rdata",  256'(bus8.readdata),      256'(0));
      chk("arst_irq",    256'(irq8),               256'(0));
      chk("arst_q6",     256'(q6),                 256'(0));
      @(negedge clock);
      drv8(1'b0, 1'b0, 1'b0, '0, '0, '0);
      resetn = 1'b1;
      @(negedge clock);
      chk("post_rst_rvalid0", 256'(bus8.readdatavalid), 256'(0));
      @(negedge clock);
      chk("post_rst_rvalid1", 256'(bus8.readdatavalid), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
